// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM states,
// default geometry and port index constants.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  localparam int DMEM_DATA_WIDTH   = 16;
  localparam int DMEM_ADDR_WIDTH   = 16;
  localparam int DMEM_STARVE_LIMIT = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // One-hot vector for a granted port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive aux-port losses; sat tells the arbiter
// to force the next contested grant to the aux port.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_r;

  // Count losses; a clear (aux grant) always wins over an increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc && (cnt_r != LIMIT_C)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU data port and an aux loader port onto a single async
// SRAM, one access per two cycles, with starvation protection for the aux port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_n_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic                  sram_we_n_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  arb_state_e state_r;
  logic       winner_r;
  logic       lat_we_n_r;
  logic       win_s;
  logic       sat_s;
  logic       inc_s;
  logic       clr_s;

  // Port 0 has priority unless port 1 has lost STARVE_LIMIT contested rounds.
  always_comb begin
    win_s = PORT_CPU;
    if (req_i == 2'b10) begin
      win_s = PORT_AUX;
    end else if ((req_i == 2'b11) && sat_s) begin
      win_s = PORT_AUX;
    end else begin
      win_s = PORT_CPU;
    end
  end

  // Counter bookkeeping only on edges where an arbitration actually happens.
  always_comb begin
    inc_s = 1'b0;
    clr_s = 1'b0;
    if (state_r == ST_IDLE) begin
      inc_s = (req_i == 2'b11) && (win_s == PORT_CPU);
      clr_s = req_i[1] && (win_s == PORT_AUX);
    end else begin
      inc_s = 1'b0;
      clr_s = 1'b0;
    end
  end

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc_s),
    .clr     (clr_s),
    .sat     (sat_s)
  );

  // Two-state access FSM; every output is a register so the SRAM sees clean levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      winner_r     <= PORT_CPU;
      lat_we_n_r   <= 1'b1;
      gnt_o        <= 2'b00;
      rvalid_o     <= 2'b00;
      busy_o       <= 1'b0;
      rdata_o      <= {DATA_WIDTH{1'b0}};
      sram_addr_o  <= {ADDR_WIDTH{1'b0}};
      sram_wdata_o <= {DATA_WIDTH{1'b0}};
      sram_we_n_o  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rvalid_o <= 2'b00;
          if (req_i != 2'b00) begin
            state_r      <= ST_ACCESS;
            winner_r     <= win_s;
            lat_we_n_r   <= we_n_i[win_s];
            gnt_o        <= port_onehot(win_s);
            busy_o       <= 1'b1;
            sram_addr_o  <= win_s ? addr1_i : addr0_i;
            sram_wdata_o <= win_s ? wdata1_i : wdata0_i;
            sram_we_n_o  <= we_n_i[win_s];
          end else begin
            state_r     <= ST_IDLE;
            gnt_o       <= 2'b00;
            busy_o      <= 1'b0;
            sram_we_n_o <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state_r     <= ST_IDLE;
          gnt_o       <= 2'b00;
          busy_o      <= 1'b0;
          sram_we_n_o <= 1'b1;
          // The SRAM read path is combinational, so data is valid at this edge.
          if (lat_we_n_r) begin
            rdata_o  <= sram_rdata_i;
            rvalid_o <= port_onehot(winner_r);
          end else begin
            rvalid_o <= 2'b00;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_o       <= 2'b00;
          rvalid_o    <= 2'b00;
          busy_o      <= 1'b0;
          sram_we_n_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural async SRAM.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_i;
  logic [1:0]  we_n_i;
  logic [15:0] addr0_i;
  logic [15:0] addr1_i;
  logic [15:0] wdata0_i;
  logic [15:0] wdata1_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [15:0] rdata_o;
  logic        busy_o;
  logic [15:0] sram_addr_o;
  logic        sram_we_n_o;
  logic [15:0] sram_wdata_o;
  logic [15:0] sram_rdata_i;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req_i),
    .we_n_i       (we_n_i),
    .addr0_i      (addr0_i),
    .addr1_i      (addr1_i),
    .wdata0_i     (wdata0_i),
    .wdata1_i     (wdata1_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .sram_addr_o  (sram_addr_o),
    .sram_we_n_o  (sram_we_n_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: combinational read, write committed while we_n is low.
  assign sram_rdata_i = mem[sram_addr_o];
  always @(posedge clk) begin
    if (!sram_we_n_o) mem[sram_addr_o] <= sram_wdata_o;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i  = 2'b00;
    we_n_i = 2'b11;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[100] = 16'hA5A5;
    mem[200] = 16'h1234;
    reset_n  = 1'b0;
    idle_inputs();
    addr0_i = 16'd0; addr1_i = 16'd0; wdata0_i = 16'd0; wdata1_i = 16'd0;
    cyc(); cyc();
    check_val("rst_outs", {30'd0, gnt_o} | {28'd0, rvalid_o, 2'b00} | {27'd0, busy_o, 4'b0000}, 32'd0);
    check_val("rst_rdata", {16'd0, rdata_o}, 32'd0);
    check_val("rst_sram", {sram_addr_o, sram_wdata_o}, 32'd0);
    check_val("rst_we_n", {31'd0, sram_we_n_o}, 32'd1);
    #3 reset_n = 1'b1;

    // Port 0 write 0x0055 @300, then read it back
    cyc();
    req_i = 2'b01; we_n_i = 2'b10; addr0_i = 16'd300; wdata0_i = 16'h0055;
    cyc();
    check_val("wr0_gnt", {30'd0, gnt_o}, 32'h1);
    check_val("wr0_we_n", {31'd0, sram_we_n_o}, 32'd0);
    check_val("wr0_busy", {31'd0, busy_o}, 32'd1);
    check_val("wr0_bus", {sram_addr_o, sram_wdata_o}, {16'd300, 16'h0055});
    idle_inputs();
    cyc();
    check_val("wr0_end", {28'd0, sram_we_n_o, busy_o, rvalid_o}, {28'd0, 1'b1, 1'b0, 2'b00});
    req_i = 2'b01; we_n_i = 2'b11; addr0_i = 16'd300;
    cyc();
    check_val("rd0_gnt", {30'd0, gnt_o}, 32'h1);
    check_val("rd0_we_n", {31'd0, sram_we_n_o}, 32'd1);
    idle_inputs();
    cyc();
    check_val("rd0_rvalid", {30'd0, rvalid_o}, 32'h1);
    check_val("rd0_rdata", {16'd0, rdata_o}, 32'h0055);
    cyc();
    check_val("rd0_rv_pulse", {30'd0, rvalid_o}, 32'h0);
    check_val("rd0_hold", {16'd0, rdata_o}, 32'h0055);

    // Port 1 alone reads 0x1234 @200
    req_i = 2'b10; we_n_i = 2'b11; addr1_i = 16'd200;
    cyc();
    check_val("rd1_gnt", {30'd0, gnt_o}, 32'h2);
    idle_inputs();
    cyc();
    check_val("rd1_rvalid", {30'd0, rvalid_o}, 32'h2);
    check_val("rd1_rdata", {16'd0, rdata_o}, 32'h1234);

    // Port 1 write 0xBEEF @5, then port 0 reads it
    req_i = 2'b10; we_n_i = 2'b01; addr1_i = 16'd5; wdata1_i = 16'hBEEF;
    cyc();
    check_val("wr1_gnt", {30'd0, gnt_o}, 32'h2);
    check_val("wr1_we_n", {31'd0, sram_we_n_o}, 32'd0);
    idle_inputs();
    cyc();
    check_val("wr1_no_rv", {30'd0, rvalid_o}, 32'h0);
    req_i = 2'b01; we_n_i = 2'b11; addr0_i = 16'd5;
    cyc();
    check_val("rd5_gnt", {30'd0, gnt_o}, 32'h1);
    idle_inputs();
    cyc();
    check_val("rd5_rvalid", {30'd0, rvalid_o}, 32'h1);
    check_val("rd5_rdata", {16'd0, rdata_o}, 32'hBEEF);

    // Both ports read continuously: 01,01,01,01,10 repeating
    req_i = 2'b11; we_n_i = 2'b11; addr0_i = 16'd100; addr1_i = 16'd200;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_val($sformatf("fair_gnt%0d", i), {30'd0, gnt_o}, (i % 5 == 4) ? 32'h2 : 32'h1);
      cyc();
      check_val($sformatf("fair_rv%0d", i), {30'd0, rvalid_o}, (i % 5 == 4) ? 32'h2 : 32'h1);
      check_val($sformatf("fair_rd%0d", i), {16'd0, rdata_o}, (i % 5 == 4) ? 32'h1234 : 32'hA5A5);
    end

    // Two contested port-0 wins, then reset during a port-0 read
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_val($sformatf("pre_gnt%0d", i), {30'd0, gnt_o}, 32'h1);
      cyc();
    end
    req_i = 2'b01; addr0_i = 16'd300;
    cyc();
    check_val("abort_gnt", {30'd0, gnt_o}, 32'h1);
    idle_inputs();
    #3 reset_n = 1'b0;
    #1;
    check_val("abort_async", {28'd0, sram_we_n_o, busy_o, gnt_o}, {28'd0, 1'b1, 1'b0, 2'b00});
    check_val("abort_rdata", {16'd0, rdata_o}, 32'h0);
    cyc();
    #3 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_val($sformatf("abort_no_rv%0d", i), {30'd0, rvalid_o}, 32'h0);
    end
    // Starvation count must restart from zero after reset
    req_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_val($sformatf("post_gnt%0d", i), {30'd0, gnt_o}, (i == 4) ? 32'h2 : 32'h1);
      cyc();
    end

    // Quiet bus for 20 cycles
    idle_inputs();
    cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_val($sformatf("idle%0d", i), {26'd0, sram_we_n_o, busy_o, gnt_o, rvalid_o}, 32'h20);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, width of SRAM address.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive port-1 losses before a forced port-1 grant.
REQ-004 SHALL use one clock, clk, and reset, reset_n; reset is asynchronous, active-low.
REQ-005 Ports, in order (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 reset_n  in  1  asynchronous active-low reset
 req_i  in  2  access request; bit0 = CPU data port, bit1 = aux loader/dump port
 we_n_i  in  2  per-port write enable, active-low (0 = write, 1 = read)
 addr0_i / addr1_i  in  ADDR_WIDTH  per-port address
 wdata0_i / wdata1_i  in  DATA_WIDTH  per-port write data
 gnt_o  out  2  one-hot grant pulse, one cycle
 rvalid_o  out  2  one-hot read-data-valid pulse, one cycle
 rdata_o  out  DATA_WIDTH  read data, shared by both ports
 busy_o  out  1  high while an SRAM access is in progress
 sram_addr_o  out  ADDR_WIDTH  to async SRAM addr
 sram_we_n_o  out  1  to async SRAM we_n
 sram_wdata_o  out  DATA_WIDTH  to async SRAM data_in
 sram_rdata_i  in  DATA_WIDTH  from async SRAM data_out (combinational read)

Function
REQ-006 SHALL implement FSM with states IDLE and ACCESS; all outputs registered.
REQ-007 IDLE with req_i == 0: SHALL stay IDLE, sram_we_n_o = 1.
REQ-008 IDLE with any req_i bit set: at the rising edge SHALL latch winner's we_n/addr/wdata and enter ACCESS.
REQ-009 Winner SHALL be port 0 when both request, unless wait_cnt == STARVE_LIMIT, in which case port 1 wins.
REQ-010 wait_cnt SHALL increment (saturating at STARVE_LIMIT) on each arbitration where both request and port 0 wins; it SHALL clear when port 1 is granted.
REQ-011 In ACCESS: sram_addr_o/sram_wdata_o SHALL present latched values; sram_we_n_o SHALL be the latched we_n; gnt_o[winner] = 1; busy_o = 1.
REQ-012 ACCESS SHALL last exactly one cycle, then return to IDLE unconditionally (max one access per 2 cycles).
REQ-013 Outside ACCESS, sram_we_n_o SHALL be 1; no SRAM write can occur in IDLE.
REQ-014 For reads, rdata_o SHALL capture sram_rdata_i at the edge ending ACCESS; rvalid_o[winner] SHALL pulse the following cycle; rdata_o holds until the next read.
REQ-015 Writes SHALL produce no rvalid_o pulse.
REQ-016 Requester SHALL hold req/we_n/addr/wdata until it sees gnt_o, then deassert req by the next edge; a req still high in IDLE is a new request.
REQ-017 Latency: req sampled at edge N -> gnt_o in cycle N+1 -> rvalid_o in cycle N+2.
REQ-018 gnt_o and rvalid_o SHALL never have more than one bit set.

Reset
REQ-019 On reset_n low, immediately: state IDLE, gnt_o = 0, rvalid_o = 0, busy_o = 0, rdata_o = 0, sram_addr_o = 0, sram_wdata_o = 0, sram_we_n_o = 1, wait_cnt = 0.
REQ-020 Reset during ACCESS SHALL abort the transaction: write is truncated, no rvalid_o is issued.
REQ-021 After reset release, first arbitration SHALL occur at the first rising edge with reset_n high.

Structure
REQ-022 Shared package dmem_arb_pkg SHALL hold the state enum, DATA_WIDTH/ADDR_WIDTH defaults, STARVE_LIMIT default and port index constants (PORT_CPU = 0, PORT_AUX = 1).
REQ-023 Starvation counter SHALL be a sub-module arb_starve_counter (inc, clr, sat output); the rest stays in dmem_arbiter.

Verification
REQ-024 Port0 write addr 300 data 0x0055, then port0 read addr 300 -> gnt_o=01 each; sram_we_n_o low only in first ACCESS cycle; rdata_o=0x0055, rvalid_o=01 two cycles after read req.
REQ-025 Both ports request continuously (reads, addr 100/200) -> grant sequence 01,01,01,01,10 repeating; wait_cnt clears after each port-1 grant.
REQ-026 Port1 alone reads addr 200 holding 0x1234 -> gnt_o=10, rvalid_o=10, rdata_o=0x1234; port0 rvalid_o bit stays 0.
REQ-027 Port1 write addr 5 data 0xBEEF -> no rvalid_o pulse; subsequent port0 read of addr 5 returns 0xBEEF.
REQ-028 Assert reset_n low mid-ACCESS of a port0 read -> sram_we_n_o=1, gnt_o=0, busy_o=0 immediately; no rvalid_o after release; wait_cnt=0.
REQ-029 Idle bus with req_i=00 for 20 cycles -> sram_we_n_o=1, busy_o=0, no gnt_o/rvalid_o pulses.
